// File: rtl/matrix_entry_ctrl.sv
// Matrix entry sequencer: collects row count, column count and row-major
// elements from debounced button pulses, emitting one write per accepted element.
module matrix_entry_ctrl #(
    parameter int MAX_DIM = 5,
    parameter int ELEM_W  = 4,
    parameter int MAX_VAL = 9,
    parameter int ADDR_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_pulse,
    input  logic              confirm_pulse,
    input  logic              cancel_pulse,
    input  logic [ELEM_W-1:0] sw_val,
    output logic              busy,
    output logic [2:0]        state_o,
    output logic [2:0]        rows_o,
    output logic [2:0]        cols_o,
    output logic [ADDR_W-1:0] elem_idx,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ELEM_W-1:0] wr_data,
    output logic              err,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_GET_ROWS  = 3'd1,
        S_GET_COLS  = 3'd2,
        S_GET_ELEMS = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    localparam int CMP_W = (ADDR_W + 1 > 6) ? ADDR_W + 1 : 6;

    state_t            r_state;
    logic [2:0]        r_rows;
    logic [2:0]        r_cols;
    logic [ADDR_W-1:0] r_idx;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [ELEM_W-1:0] r_wr_data;
    logic              r_err;
    logic              r_done;

    logic              w_dim_ok;
    logic              w_val_ok;
    logic [5:0]        w_prod;
    logic [CMP_W-1:0]  w_next_cnt;
    logic              w_last;

    assign w_dim_ok   = (sw_val != '0) && (sw_val <= ELEM_W'(MAX_DIM));
    assign w_val_ok   = (sw_val <= ELEM_W'(MAX_VAL));
    assign w_prod     = {3'b000, r_rows} * {3'b000, r_cols};
    // The element being accepted now is the last one when the written count reaches rows*cols.
    assign w_next_cnt = CMP_W'(r_idx) + CMP_W'(1);
    assign w_last     = (CMP_W'(w_prod) == w_next_cnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_rows    <= '0;
            r_cols    <= '0;
            r_idx     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_err     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_pulse) begin
                        r_state <= S_GET_ROWS;
                        r_err   <= 1'b0;
                        r_idx   <= '0;
                    end
                end
                S_GET_ROWS: begin
                    if (cancel_pulse) begin
                        r_state <= S_IDLE;
                    end else if (confirm_pulse) begin
                        if (w_dim_ok) begin
                            r_rows  <= sw_val[2:0];
                            r_err   <= 1'b0;
                            r_state <= S_GET_COLS;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_GET_COLS: begin
                    if (cancel_pulse) begin
                        r_state <= S_IDLE;
                    end else if (confirm_pulse) begin
                        if (w_dim_ok) begin
                            r_cols  <= sw_val[2:0];
                            r_err   <= 1'b0;
                            r_idx   <= '0;
                            r_state <= S_GET_ELEMS;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_GET_ELEMS: begin
                    if (cancel_pulse) begin
                        r_state <= S_IDLE;
                    end else if (confirm_pulse) begin
                        if (w_val_ok) begin
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= r_idx;
                            r_wr_data <= sw_val;
                            r_idx     <= r_idx + ADDR_W'(1);
                            r_err     <= 1'b0;
                            if (w_last) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign state_o  = r_state;
    assign rows_o   = r_rows;
    assign cols_o   = r_cols;
    assign elem_idx = r_idx;
    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign err      = r_err;
    assign done     = r_done;

endmodule
